// File: rtl/anton_neopixel_decoder_pkg.sv
// Shared constants and state encoding for the neopixel receive path.
// The nominal pulse timings match the transmitter, so both ends stay in step.
package anton_neopixel_decoder_pkg;

  localparam int BYTES_MAX_DEF    = 66;
  localparam int HIGH_MIN_DEF     = 2;
  localparam int HIGH_ONE_DEF     = 6;
  localparam int HIGH_MAX_DEF     = 12;
  localparam int RESET_CYCLES_DEF = 500;

  // Transmitter pulse shapes in clk10mhz cycles.
  localparam int T0H     = 4;
  localparam int T1H     = 8;
  localparam int T_RESET = 500;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } dec_state_e;

endpackage

// File: rtl/anton_neopixel_pulse_meter.sv
// Synchronises the raw neopixel line, flags its edges and measures how long
// the line has held its current level.
module anton_neopixel_pulse_meter #(
  parameter int SAT = 500,
  parameter int W   = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         din,
  output logic         level,
  output logic         rise,
  output logic         fall,
  output logic [W-1:0] width
);

  logic         sync1_q, sync1_d;
  logic         sync2_q, sync2_d;
  logic         prev_q, prev_d;
  logic [W-1:0] width_q, width_d;
  logic         edge_seen;

  // The edge cycle is the first cycle of the new run, so the counter restarts
  // at 1; on the next edge it then holds the full length of the finished run.
  always_comb begin
    sync1_d   = din;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    edge_seen = sync2_q ^ prev_q;
    if (edge_seen) begin
      width_d = W'(1);
    end else if (width_q < W'(SAT)) begin
      width_d = width_q + W'(1);
    end else begin
      width_d = width_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      width_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      width_q <= width_d;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;
  assign fall  = ~sync2_q & prev_q;
  assign width = width_q;

endmodule

// File: rtl/anton_neopixel_decoder.sv
// WS2812-style receiver: turns high-pulse widths into bits, bits into
// addressed bytes, and reports frame completion, width errors and overflow.
module anton_neopixel_decoder
  import anton_neopixel_decoder_pkg::*;
#(
  parameter int BYTES_MAX    = BYTES_MAX_DEF,
  parameter int HIGH_MIN     = HIGH_MIN_DEF,
  parameter int HIGH_ONE     = HIGH_ONE_DEF,
  parameter int HIGH_MAX     = HIGH_MAX_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic                             clk10mhz,
  input  logic                             reset,
  input  logic                             neoData,
  output logic [7:0]                       byteData,
  output logic [$clog2(BYTES_MAX)-1:0]     byteAddr,
  output logic                             byteValid,
  output logic                             frameDone,
  output logic [$clog2(BYTES_MAX+1)-1:0]   frameBytes,
  output logic                             errorPulse,
  output logic                             overflow
);

  localparam int AW = $clog2(BYTES_MAX);
  localparam int FW = $clog2(BYTES_MAX + 1);
  localparam int CW = $clog2(RESET_CYCLES + 1);

  logic          level, rise, fall;
  logic [CW-1:0] width;

  anton_neopixel_pulse_meter #(
    .SAT (RESET_CYCLES),
    .W   (CW)
  ) u_meter (
    .clk   (clk10mhz),
    .reset (reset),
    .din   (neoData),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .width (width)
  );

  dec_state_e    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic [AW-1:0] byte_addr_q, byte_addr_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [FW-1:0] frame_bytes_q, frame_bytes_d;
  logic          error_q, error_d;
  logic          overflow_q, overflow_d;
  logic          bit_one;
  logic [7:0]    new_shift;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_data_d   = byte_data_q;
    byte_addr_d   = byte_addr_q;
    byte_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    frame_bytes_d = frame_bytes_q;
    error_d       = 1'b0;
    overflow_d    = (frame_done_q || state_q == ST_SYNC) ? 1'b0 : overflow_q;
    bit_one       = (width >= CW'(HIGH_ONE));
    new_shift     = {shift_q[6:0], bit_one};

    unique case (state_q)
      ST_SYNC: begin
        // The falling-edge cycle still carries the length of the high run.
        if (!level && !fall && width >= CW'(RESET_CYCLES)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        if (rise) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (width > CW'(HIGH_MAX) || (fall && width < CW'(HIGH_MIN))) begin
          error_d = 1'b1;
          state_d = ST_SYNC;
        end else if (fall) begin
          shift_d = new_shift;
          state_d = ST_LOW;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            if (byte_cnt_q < FW'(BYTES_MAX)) begin
              byte_valid_d = 1'b1;
              byte_data_d  = new_shift;
              byte_addr_d  = AW'(byte_cnt_q);
              byte_cnt_d   = byte_cnt_q + FW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
        end else if (width >= CW'(RESET_CYCLES)) begin
          state_d    = ST_IDLE;
          error_d    = (bit_cnt_q != 3'd0);
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          if (byte_cnt_q != '0) begin
            frame_done_d  = 1'b1;
            frame_bytes_d = byte_cnt_q;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk10mhz) begin
    if (reset) begin
      state_q       <= ST_SYNC;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      byte_data_q   <= '0;
      byte_addr_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_bytes_q <= '0;
      error_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_data_q   <= byte_data_d;
      byte_addr_q   <= byte_addr_d;
      byte_valid_q  <= byte_valid_d;
      frame_done_q  <= frame_done_d;
      frame_bytes_q <= frame_bytes_d;
      error_q       <= error_d;
      overflow_q    <= overflow_d;
    end
  end

  assign byteData   = byte_data_q;
  assign byteAddr   = byte_addr_q;
  assign byteValid  = byte_valid_q;
  assign frameDone  = frame_done_q;
  assign frameBytes = frame_bytes_q;
  assign errorPulse = error_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_anton_neopixel_decoder.sv
// Directed bench for the neopixel decoder: drives pulse-width encoded frames
// and checks decoded bytes, frame reports, errors and overflow.
`timescale 1ns/1ps
module tb_anton_neopixel_decoder;

  logic       clk10mhz = 1'b0;
  logic       reset;
  logic       neoData;
  logic [7:0] byteData;
  logic [6:0] byteAddr;
  logic       byteValid;
  logic       frameDone;
  logic [6:0] frameBytes;
  logic       errorPulse;
  logic       overflow;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [7:0] logData[$];
  logic [6:0] logAddr[$];
  int         bvCyc, fdCount, fdCyc, errCount, errCyc, lastFallCyc;
  logic [6:0] fdBytes;
  logic       fdOvf, ovfAfter, ovfPending;

  anton_neopixel_decoder dut (
    .clk10mhz   (clk10mhz),
    .reset      (reset),
    .neoData    (neoData),
    .byteData   (byteData),
    .byteAddr   (byteAddr),
    .byteValid  (byteValid),
    .frameDone  (frameDone),
    .frameBytes (frameBytes),
    .errorPulse (errorPulse),
    .overflow   (overflow)
  );

  always #50 clk10mhz = ~clk10mhz;

  always @(posedge clk10mhz) cyc <= cyc + 1;

  // Strobes are one cycle wide, so they are logged on every falling clock edge.
  always @(negedge clk10mhz) begin
    if (ovfPending) begin
      ovfAfter   = overflow;
      ovfPending = 1'b0;
    end
    if (byteValid) begin
      logData.push_back(byteData);
      logAddr.push_back(byteAddr);
      bvCyc = cyc;
    end
    if (frameDone) begin
      fdCount++;
      fdBytes    = frameBytes;
      fdCyc      = cyc;
      fdOvf      = overflow;
      ovfPending = 1'b1;
    end
    if (errorPulse) begin
      errCount++;
      errCyc = cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed no finish, required finish within 5 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearLog();
    logData.delete();
    logAddr.delete();
    bvCyc      = -1;
    fdCount    = 0;
    fdCyc      = -1;
    fdBytes    = '0;
    fdOvf      = 1'b0;
    errCount   = 0;
    errCyc     = -2;
    ovfAfter   = 1'bx;
    ovfPending = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic driveLevel(input logic value, input int cycles);
    neoData = value;
    repeat (cycles) @(posedge clk10mhz);
    #1;
  endtask

  task automatic idleLow(input int cycles);
    driveLevel(1'b0, cycles);
  endtask

  // Sends the top nbits of value MSB first: one = high 8/low 4, zero = high 4/low 8.
  task automatic applyStimulus(input logic [7:0] value, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      if (value[i]) begin
        driveLevel(1'b1, 8);
        lastFallCyc = cyc;
        driveLevel(1'b0, 4);
      end else begin
        driveLevel(1'b1, 4);
        lastFallCyc = cyc;
        driveLevel(1'b0, 8);
      end
    end
  endtask

  function automatic logic [7:0] dataAt(input int idx);
    if (idx < logData.size()) return logData[idx];
    return 8'hxx;
  endfunction

  function automatic logic [6:0] addrAt(input int idx);
    if (idx < logAddr.size()) return logAddr[idx];
    return 7'hxx;
  endfunction

  function automatic logic [7:0] patternByte(input int idx);
    return 8'((idx * 7) + 3);
  endfunction

  initial begin
    int badEntries;
    reset   = 1'b1;
    neoData = 1'b0;
    clearLog();
    repeat (5) @(posedge clk10mhz);
    #1;
    checkOutput("reset byteValid", byteValid, 0);
    checkOutput("reset byteData", byteData, 0);
    checkOutput("reset frameDone", frameDone, 0);
    checkOutput("reset frameBytes", frameBytes, 0);
    checkOutput("reset errorPulse", errorPulse, 0);
    checkOutput("reset overflow", overflow, 0);
    reset = 1'b0;
    idleLow(520);
    clearLog();

    $display("[TB] single byte 0xA5");
    applyStimulus(8'hA5, 8);
    idleLow(520);
    checkOutput("a5 count", logData.size(), 1);
    checkOutput("a5 data", dataAt(0), 8'hA5);
    checkOutput("a5 addr", addrAt(0), 0);
    checkOutput("a5 latency", bvCyc - lastFallCyc, 3);
    checkOutput("a5 frameDone", fdCount, 1);
    checkOutput("a5 frameBytes", fdBytes, 1);
    checkOutput("a5 errors", errCount, 0);

    $display("[TB] three bytes 0x00 0xFF 0x3C");
    clearLog();
    applyStimulus(8'h00, 8);
    applyStimulus(8'hFF, 8);
    applyStimulus(8'h3C, 8);
    idleLow(520);
    checkOutput("3b count", logData.size(), 3);
    checkOutput("3b data0", dataAt(0), 8'h00);
    checkOutput("3b addr0", addrAt(0), 0);
    checkOutput("3b data1", dataAt(1), 8'hFF);
    checkOutput("3b addr1", addrAt(1), 1);
    checkOutput("3b data2", dataAt(2), 8'h3C);
    checkOutput("3b addr2", addrAt(2), 2);
    checkOutput("3b frameBytes", fdBytes, 3);
    checkOutput("3b held frameBytes", frameBytes, 3);
    checkOutput("3b errors", errCount, 0);

    $display("[TB] glitch mid-byte");
    clearLog();
    applyStimulus(8'hA0, 3);
    driveLevel(1'b1, 1);
    driveLevel(1'b0, 8);
    applyStimulus(8'hFF, 5);
    checkOutput("glitch error", errCount, 1);
    checkOutput("glitch no byte", logData.size(), 0);
    idleLow(520);
    checkOutput("glitch no frame", fdCount, 0);
    applyStimulus(8'h5A, 8);
    idleLow(520);
    checkOutput("recover count", logData.size(), 1);
    checkOutput("recover data", dataAt(0), 8'h5A);
    checkOutput("recover frameBytes", fdBytes, 1);
    checkOutput("recover errors", errCount, 1);

    $display("[TB] twelve bits");
    clearLog();
    applyStimulus(8'hC3, 8);
    applyStimulus(8'hA0, 4);
    idleLow(520);
    checkOutput("12b count", logData.size(), 1);
    checkOutput("12b data", dataAt(0), 8'hC3);
    checkOutput("12b errors", errCount, 1);
    checkOutput("12b frameDone", fdCount, 1);
    checkOutput("12b frameBytes", fdBytes, 1);
    checkOutput("12b error with frameDone", errCyc, fdCyc);

    $display("[TB] overflow with 68 bytes");
    clearLog();
    for (int i = 0; i < 66; i++) applyStimulus(patternByte(i), 8);
    checkOutput("ovf before 67th", overflow, 0);
    applyStimulus(patternByte(66), 8);
    checkOutput("ovf at 67th", overflow, 1);
    applyStimulus(patternByte(67), 8);
    idleLow(520);
    checkOutput("ovf count", logData.size(), 66);
    badEntries = 0;
    for (int i = 0; i < 66; i++) begin
      if (dataAt(i) !== patternByte(i) || addrAt(i) !== 7'(i)) badEntries++;
    end
    checkOutput("ovf bad entries", badEntries, 0);
    checkOutput("ovf frameBytes", fdBytes, 66);
    checkOutput("ovf at frameDone", fdOvf, 1);
    checkOutput("ovf after frameDone", ovfAfter, 0);
    checkOutput("ovf errors", errCount, 0);

    $display("[TB] reset mid-frame");
    clearLog();
    applyStimulus(8'hF0, 4);
    reset = 1'b1;
    @(posedge clk10mhz);
    #1;
    reset = 1'b0;
    checkOutput("rst byteData", byteData, 0);
    checkOutput("rst byteAddr", byteAddr, 0);
    checkOutput("rst frameBytes", frameBytes, 0);
    checkOutput("rst overflow", overflow, 0);
    applyStimulus(8'h50, 4);
    idleLow(520);
    checkOutput("rst no byte", logData.size(), 0);
    checkOutput("rst no frame", fdCount, 0);
    checkOutput("rst no error", errCount, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_decoder.md
Name: anton_neopixel_decoder

Overview:
Receive-side counterpart of the neopixel transmitter. Samples a WS2812-style single-wire stream on clk10mhz and recovers bits from high-pulse widths. Assembles the bits into bytes and presents each byte with a byte address, in the same byte layout the transmitter's bus writes use. Used for loopback self-test of the controller (neoData fed back) and as a bench monitor.

Parameters:
BYTES_MAX, 66, max bytes stored per frame; address width = `CLOG2(BYTES_MAX)`.
HIGH_MIN, 2, shortest legal high pulse in clk10mhz cycles; shorter is a glitch error.
HIGH_ONE, 6, high width >= this decodes as 1, below decodes as 0.
HIGH_MAX, 12, longest legal high pulse; longer is a stuck-high error.
RESET_CYCLES, 500, low time (50 us) that terminates a frame.

Ports:
clk10mhz  in  1  sole clock, 10 MHz
reset  in  1  synchronous, active-high
neoData  in  1  asynchronous serial input
byteData  out  8  decoded byte, MSB received first
byteAddr  out  `CLOG2(BYTES_MAX)`  index of byteData within the current frame
byteValid  out  1  one-cycle strobe, byteData/byteAddr valid
frameDone  out  1  one-cycle strobe at end of a frame
frameBytes  out  `CLOG2(BYTES_MAX+1)`  bytes received in the last completed frame; held until the next frameDone
errorPulse  out  1  one-cycle strobe on a width error or partial byte
overflow  out  1  sticky within a frame; set when more than BYTES_MAX bytes arrive

Behaviour:
- neoData passes through a 2-flop synchroniser; all timing uses the second flop (neoSync).
- Reset values: all outputs 0; state SYNC; counters 0.
- One width counter, `CLOG2(RESET_CYCLES+1)` bits, saturates at RESET_CYCLES and never wraps. Cleared on every neoSync edge.
- States:
  - SYNC: after reset or error. Wait for neoSync low for RESET_CYCLES consecutive cycles, then go to IDLE. No output strobes in this state.
  - IDLE: wait for a rising edge, then go to HIGH. Bit count = 0, byte count = 0.
  - HIGH: count cycles while high.
    - Falling edge with width < HIGH_MIN, or width reaching HIGH_MAX+1 while still high: errorPulse, then SYNC.
    - Otherwise shift in the bit (1 if width >= HIGH_ONE) and go to LOW.
  - LOW: count cycles while low.
    - Rising edge before RESET_CYCLES: go to HIGH. Inter-bit gap length is otherwise unchecked.
    - Low count reaching RESET_CYCLES: end of frame. Go to IDLE.
- Byte emit:
  - Registered. byteValid asserts the cycle after the falling edge that completes the 8th bit.
  - Latency from the neoData pin falling to byteValid is 3 cycles.
  - byteAddr = byte count before increment.
  - Byte count saturates at BYTES_MAX.
  - For bytes past BYTES_MAX: byteValid is suppressed and overflow is set.
- End of frame:
  - frameDone pulses only if at least one complete byte was received.
  - frameBytes = min(byte count, BYTES_MAX), updated on the same cycle frameDone rises.
  - Bit count != 0 at frame end: errorPulse in the same cycle. The partial byte is discarded; complete bytes still count.
  - overflow clears on the cycle after frameDone.
- A frame with zero complete bytes produces neither frameDone nor an frameBytes update.
- Simultaneous events: a frame end coinciding with a pending byte emit is impossible by construction, since emit occurs at a falling edge and frame end at the end of a low run. Error has priority over bit decode.
- Reset mid-frame: everything returns to reset values next cycle, state SYNC. The interrupted frame is never reported.

Decomposition:
- Shared package/header (anton_common.vh): `CLOG2` and the default timing constants T0H/T1H/RESET in clk10mhz cycles, so that transmitter and decoder share one source.
- Sub-module anton_neopixel_pulse_meter: synchroniser, edge detect and saturating width counter. Outputs rise/fall strobes and the width.
- Decoder FSM and byte assembly stay in the top module.

Test Plan:
- After reset, hold neoData low for 500 cycles, then send 0xA5 (one bit = high 8/low 4, zero bit = high 4/low 8), then low for 500 -> byteValid once with byteData=0xA5, byteAddr=0; frameDone with frameBytes=1; no errorPulse.
- Send 3 bytes 0x00,0xFF,0x3C back-to-back, then 500 low -> byteAddr 0,1,2 with matching data; frameBytes=3.
- Inject a 1-cycle high glitch mid-byte -> errorPulse; no byteValid until 500 low cycles plus a fresh frame, which then decodes correctly.
- Send 12 bits then 500 low -> one byteValid; errorPulse at frame end; frameDone with frameBytes=1.
- Send BYTES_MAX+2 = 68 bytes -> 66 byteValid strobes; overflow=1 from the 67th byte; frameBytes=66; overflow=0 the cycle after frameDone.
- Assert reset for 1 cycle after 4 bits of a byte -> all outputs 0; the remaining bits of the frame produce no strobes.
